mont_const_gen: RTL and testbench
=================================

MONT_CONST_GEN -- requirements
Module: mont_const_gen

Interface
REQ-001 The block SHALL have parameter K, default 8, giving the operand width in bits; R = 2^K.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide: request pulse that starts a constant computation.
REQ-005 Port m SHALL be an input, K bits wide: the modulus, sampled only on an accepted start.
REQ-006 Port R_mod_m SHALL be an output register, K bits wide, holding 2^K mod m.
REQ-007 Port R2_mod_m SHALL be an output register, K bits wide, holding 2^(2K) mod m.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while a computation is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse that marks R_mod_m, R2_mod_m and err as valid.
REQ-010 Port err SHALL be an output, 1 bit wide: modulus rejected; qualified by done and held until the next accepted start.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: waiting for start.
- RUN: iterating.
- DONE: issuing the done pulse.
REQ-012 A start SHALL be accepted only in IDLE; start SHALL be ignored in RUN and in DONE.
REQ-013 On an accepted start, the block SHALL latch m into m_q, clear err, and check m_q; a modulus that is even or less than 3 SHALL be invalid.
REQ-014 For an invalid m, the block SHALL:
- go directly to DONE;
- set err=1;
- drive R_mod_m=0 and R2_mod_m=0.
REQ-015 For a valid m, the block SHALL:
- load r=1 and iteration counter i=0;
- enter RUN.
REQ-016 Each RUN cycle SHALL perform one doubling step:
- t = 2r, computed K+1 bits wide;
- r <= (t >= m_q) ? t - m_q : t;
- i <= i+1.
The invariant r < m_q SHALL hold, so one conditional subtract suffices.
REQ-017 The register R_mod_m SHALL load the stepped r on the step where i == K-1.
REQ-018 The register R2_mod_m SHALL load the stepped r on the step where i == 2K-1; that step SHALL also transition the FSM to DONE.
REQ-019 The done output SHALL be high exactly while the FSM is in DONE, which SHALL last one cycle, after which the FSM SHALL return to IDLE.
REQ-020 Latency for a valid m: with start sampled at edge T, done SHALL be high in the cycle after edge T+2K, i.e. 2K+1 cycles after start (17 for K=8). For an invalid m, done SHALL be high after 1 cycle.
REQ-021 The busy output SHALL be high in RUN and in DONE, and low in IDLE.
REQ-022 R_mod_m, R2_mod_m and err SHALL hold their values from done until the next accepted start; they SHALL change only during RUN or on acceptance.
REQ-023 A change on m SHALL have no effect on a computation in progress.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL clear all of the following to 0 and go to IDLE:
- outputs R_mod_m, R2_mod_m, busy, done, err;
- internal registers r, i, m_q.
REQ-025 A reset mid-RUN SHALL abort the computation; no done SHALL be issued for the aborted request.
REQ-026 If start and rst_n=0 occur in the same cycle, reset SHALL win and the start SHALL be lost.

Configuration
REQ-027 The macro MONT_CONST_CACHE_EN SHALL control result caching.
- Defined: the block keeps a valid flag, set at each successful done and cleared by reset and by any err. An accepted start with valid=1 and m == m_q SHALL skip RUN: DONE follows in the next cycle (1-cycle latency) with the outputs unchanged.
- Undefined: every accepted start SHALL run the full 2K iterations, and no valid flag SHALL exist.

Verification
REQ-028 K=8, m=13, start -> done 17 cycles later; R_mod_m=9, R2_mod_m=3, err=0.
REQ-029 K=8, m=251, then m=255 in a second request -> first (R_mod_m=5, R2_mod_m=25), second (R_mod_m=1, R2_mod_m=1).
REQ-030 K=8, m=12, and separately m=1 -> done 1 cycle after start; err=1, R_mod_m=0, R2_mod_m=0.
REQ-031 K=8, m=13, start pulsed again at cycle 5 of RUN -> single done at cycle 17 with R_mod_m=9 and R2_mod_m=3; the second start is ignored.
REQ-032 K=8, m=13, rst_n=0 at cycle 8 of RUN -> no done; all outputs 0; a fresh start then completes in 17 cycles with the correct values.
REQ-033 With MONT_CONST_CACHE_EN defined, K=8, m=13 twice -> first done at 17 cycles, second done at 1 cycle with R_mod_m=9 and R2_mod_m=3; without the macro, both requests take 17 cycles.

Source files
------------

// File: rtl/mont_const_gen.sv
// mont_const_gen: computes the Montgomery constants R mod m and R^2 mod m
// (R = 2^K) for an odd modulus m >= 3 by 2K modular doubling steps.
//
// Optional feature: define MONT_CONST_CACHE_EN to keep a result-valid flag.
// A start for the same modulus as the last successful run then skips the
// iteration and answers in one cycle with the outputs untouched.
module mont_const_gen #(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] m,
    output logic [K-1:0] R_mod_m,
    output logic [K-1:0] R2_mod_m,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int IW = $clog2(2 * K);
    localparam logic [IW-1:0] LAST_R  = IW'(K - 1);
    localparam logic [IW-1:0] LAST_R2 = IW'(2 * K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [K-1:0]  m_q, m_d;
    logic [K-1:0]  r_q, r_d;
    logic [IW-1:0] i_q, i_d;
    logic [K-1:0]  rm_q, rm_d;
    logic [K-1:0]  r2_q, r2_d;
    logic          err_q, err_d;

    logic          accept;
    logic          m_invalid;
    logic          last_step;
    logic          cache_hit;
    logic [K:0]    t;
    logic [K:0]    m_ext;
    logic [K-1:0]  r_step;

    assign accept    = (state_q == IDLE) && start;
    assign m_invalid = ~m[0] || (m < K'(3));
    assign last_step = (state_q == RUN) && (i_q == LAST_R2);

    // One doubling step: r < m_q keeps 2r < 2m_q, so a single subtract
    // brings the result back into range.
    assign t      = {r_q, 1'b0};
    assign m_ext  = {1'b0, m_q};
    assign r_step = K'((t >= m_ext) ? (t - m_ext) : t);

`ifdef MONT_CONST_CACHE_EN
    logic valid_q, valid_d;

    assign cache_hit = valid_q && (m == m_q);

    // Result-valid flag: set by a completed run, dropped by a rejected modulus.
    always_comb begin
        valid_d = valid_q;
        if (accept && m_invalid) begin
            valid_d = 1'b0;
        end else if (last_step) begin
            valid_d = 1'b1;
        end
    end

    // Cache flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        i_d     = i_q;
        rm_d    = rm_q;
        r2_d    = r2_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = m;
                    err_d = 1'b0;
                    if (m_invalid) begin
                        err_d   = 1'b1;
                        rm_d    = '0;
                        r2_d    = '0;
                        state_d = DONE;
                    end else if (cache_hit) begin
                        state_d = DONE;
                    end else begin
                        r_d     = K'(1);
                        i_d     = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d = r_step;
                i_d = i_q + IW'(1);
                if (i_q == LAST_R) begin
                    rm_d = r_step;
                end
                if (i_q == LAST_R2) begin
                    r2_d    = r_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
            rm_q    <= '0;
            r2_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            i_q     <= i_d;
            rm_q    <= rm_d;
            r2_q    <= r2_d;
            err_q   <= err_d;
        end
    end

    assign R_mod_m  = rm_q;
    assign R2_mod_m = r2_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mont_const_gen.sv
// Self-checking bench for mont_const_gen (K=8): directed and random moduli
// checked against plain modular arithmetic, plus restart, reset and hold cases.
module tb_mont_const_gen;

    localparam int K = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [K-1:0] m;
    logic [K-1:0] R_mod_m;
    logic [K-1:0] R2_mod_m;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference cache state (only consulted when caching is compiled in).
    bit           mdl_valid = 1'b0;
    logic [K-1:0] mdl_m = '0;

    mont_const_gen #(.K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .m        (m),
        .R_mod_m  (R_mod_m),
        .R2_mod_m (R2_mod_m),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic bit ref_invalid(input logic [K-1:0] mv);
        return (mv[0] == 1'b0) || (mv < 3);
    endfunction

    function automatic logic [K-1:0] ref_pow_mod(input logic [K-1:0] mv, input int e);
        longint p;
        if (ref_invalid(mv)) return '0;
        p = longint'(1) << e;
        return K'(p % longint'(mv));
    endfunction

    function automatic int ref_lat(input logic [K-1:0] mv);
        if (ref_invalid(mv)) return 1;
`ifdef MONT_CONST_CACHE_EN
        if (mdl_valid && mdl_m == mv) return 1;
`endif
        return 2 * K + 1;
    endfunction

    task automatic model_update(input logic [K-1:0] mv);
        mdl_valid = !ref_invalid(mv);
        mdl_m     = mv;
    endtask

    // Issue one request; optionally pulse start with another modulus at
    // cycle poke_at of the run. lat counts edges from acceptance to done.
    task automatic run_req(input logic [K-1:0] mv, input int poke_at,
                           input logic [K-1:0] poke_m, output int lat, output bit got);
        @(negedge clk);
        start = 1'b1;
        m     = mv;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        got   = 1'b0;
        while (lat <= 100) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (lat == poke_at) begin
                start = 1'b1;
                m     = poke_m;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({R_mod_m, R2_mod_m, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got R=%0d R2=%0d busy=%b done=%b err=%b want all 0",
                     R_mod_m, R2_mod_m, busy, done, err);
        end
        rst_n = 1'b1;
        mdl_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [K-1:0] vec [6] = '{8'd13, 8'd251, 8'd255, 8'd12, 8'd1, 8'd0};
        int lat;
        bit got;
        int exp_lat;
        for (int n = 0; n < 6; n++) begin
            exp_lat = ref_lat(vec[n]);
            run_req(vec[n], 0, '0, lat, got);
            checks++;
            if (!got || lat !== exp_lat) begin
                errors++;
                $display("FAIL dir_latency m=%0d got=%0d (seen=%b) want=%0d", vec[n], lat, got, exp_lat);
            end
            checks++;
            if (R_mod_m !== ref_pow_mod(vec[n], K) || R2_mod_m !== ref_pow_mod(vec[n], 2 * K)) begin
                errors++;
                $display("FAIL dir_values m=%0d got R=%0d R2=%0d want R=%0d R2=%0d", vec[n],
                         R_mod_m, R2_mod_m, ref_pow_mod(vec[n], K), ref_pow_mod(vec[n], 2 * K));
            end
            checks++;
            if (err !== ref_invalid(vec[n])) begin
                errors++;
                $display("FAIL dir_err m=%0d got=%b want=%b", vec[n], err, ref_invalid(vec[n]));
            end
            model_update(vec[n]);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir_pulse_end m=%0d got done=%b busy=%b want 0 0", vec[n], done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [K-1:0] mv;
        int lat;
        bit got;
        int exp_lat;
        for (int n = 0; n < 24; n++) begin
            mv = K'($urandom_range(0, 255));
            if (n % 4 != 0) mv[0] = 1'b1;
            exp_lat = ref_lat(mv);
            run_req(mv, 0, '0, lat, got);
            checks++;
            if (!got || lat !== exp_lat) begin
                errors++;
                $display("FAIL rnd_latency m=%0d got=%0d (seen=%b) want=%0d", mv, lat, got, exp_lat);
            end
            checks++;
            if (R_mod_m !== ref_pow_mod(mv, K) || R2_mod_m !== ref_pow_mod(mv, 2 * K)
                || err !== ref_invalid(mv)) begin
                errors++;
                $display("FAIL rnd_values m=%0d got R=%0d R2=%0d err=%b want R=%0d R2=%0d err=%b",
                         mv, R_mod_m, R2_mod_m, err, ref_pow_mod(mv, K),
                         ref_pow_mod(mv, 2 * K), ref_invalid(mv));
            end
            model_update(mv);
        end
    endtask

    task automatic test_restart_ignored();
        int lat;
        bit got;
        int extra;
        run_req(8'd12, 0, '0, lat, got);
        model_update(8'd12);
        run_req(8'd13, 5, 8'd77, lat, got);
        model_update(8'd13);
        checks++;
        if (!got || lat !== 17 || R_mod_m !== 8'd9 || R2_mod_m !== 8'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored got lat=%0d R=%0d R2=%0d err=%b want lat=17 R=9 R2=3 err=0",
                     lat, R_mod_m, R2_mod_m, err);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL restart_single_done got extra=%0d want 0", extra);
        end
    endtask

    task automatic test_hold();
        checks++;
        m = 8'd7;
        repeat (6) @(negedge clk);
        if (R_mod_m !== 8'd9 || R2_mod_m !== 8'd3 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold got R=%0d R2=%0d err=%b busy=%b want R=9 R2=3 err=0 busy=0",
                     R_mod_m, R2_mod_m, err, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit got;
        int seen;
        @(negedge clk);
        start = 1'b1;
        m     = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_busy got busy=%b done=%b want 1 0", busy, done);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_valid = 1'b0;
        checks++;
        if ({R_mod_m, R2_mod_m, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got R=%0d R2=%0d busy=%b done=%b err=%b want all 0",
                     R_mod_m, R2_mod_m, busy, done, err);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_done got active_cycles=%0d want 0", seen);
        end
        run_req(8'd13, 0, '0, lat, got);
        model_update(8'd13);
        checks++;
        if (!got || lat !== 17 || R_mod_m !== 8'd9 || R2_mod_m !== 8'd3) begin
            errors++;
            $display("FAIL midrun_fresh got lat=%0d R=%0d R2=%0d want lat=17 R=9 R2=3",
                     lat, R_mod_m, R2_mod_m);
        end
    endtask

    task automatic test_reset_start_collide();
        int seen;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        m     = 8'd13;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        mdl_valid = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || R_mod_m !== '0 || R2_mod_m !== '0) begin
            errors++;
            $display("FAIL collide got active_cycles=%0d R=%0d R2=%0d want 0 0 0",
                     seen, R_mod_m, R2_mod_m);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        int exp2;
`ifdef MONT_CONST_CACHE_EN
        exp2 = 1;
`else
        exp2 = 17;
`endif
        run_req(8'd12, 0, '0, lat, got);
        model_update(8'd12);
        run_req(8'd13, 0, '0, lat, got);
        model_update(8'd13);
        checks++;
        if (!got || lat !== 17) begin
            errors++;
            $display("FAIL b2b_first_latency got=%0d want=17", lat);
        end
        run_req(8'd13, 0, '0, lat, got);
        model_update(8'd13);
        checks++;
        if (!got || lat !== exp2 || R_mod_m !== 8'd9 || R2_mod_m !== 8'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d R=%0d R2=%0d err=%b want lat=%0d R=9 R2=3 err=0",
                     lat, R_mod_m, R2_mod_m, err, exp2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart_ignored();
        test_hold();
        test_reset_midrun();
        test_reset_start_collide();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
